// File: rtl/uart_tx_gen_if.sv
// uart_tx_gen_if: valid/ready streaming handshake between a data source and
// the uart_tx_gen transmitter. The source drives master, the transmitter
// takes the slave side.
interface uart_tx_gen_if #(
  parameter int MAX_DW = 8
) ();
  logic              in_valid;
  logic [MAX_DW-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/uart_tx_gen.sv
// uart_tx_gen: parametrised UART transmitter.
// Oversampling ratio and maximum data width are parameters. Frame format
// (data length, parity, stop length) is sampled from the inputs when a word
// is accepted and held for the whole frame. Bit timing comes from the shared
// baud_pulse tick. The serial pin is registered one clk behind the FSM.
// Optional build macro UART_TX_CTS_EN adds a cts_n flow-control input that
// gates acceptance of new words.
module uart_tx_gen #(
  parameter int  OVERSAMPLE = 16,
  parameter int  MAX_DW     = 8,
  localparam int CNT_W      = $clog2(2*OVERSAMPLE),
  localparam int DL_W       = $clog2(MAX_DW+1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            baud_pulse,
  uart_tx_gen_if.slave    in_if,
  input  logic [DL_W-1:0] dlen,
  input  logic            pen,
  input  logic            eps,
  input  logic            sticky_parity,
  input  logic            stb,
  input  logic            set_break,
`ifdef UART_TX_CTS_EN
  input  logic            cts_n,
`endif
  output logic            tx,
  output logic            busy,
  output logic            frame_done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  localparam logic [CNT_W-1:0] BIT_RLD  = CNT_W'(OVERSAMPLE-1);
  localparam logic [CNT_W-1:0] STOP15_R = CNT_W'(3*OVERSAMPLE/2-1);
  localparam logic [CNT_W-1:0] STOP2_R  = CNT_W'(2*OVERSAMPLE-1);
  localparam logic [DL_W-1:0]  DL_MIN   = DL_W'(5);
  localparam logic [DL_W-1:0]  DL_MAX   = DL_W'(MAX_DW);

  state_e            state_q;
  logic [CNT_W-1:0]  timer_q;
  logic [MAX_DW-1:0] sh_q;
  logic [DL_W-1:0]   bitcnt_q;
  logic [DL_W-1:0]   dlen_q;
  logic              pen_q;
  logic              stb_q;
  logic              par_q;
  logic              tx_data_q;
  logic              tx_q;
  logic              busy_q;
  logic              done_q;

  logic [DL_W-1:0]   dlen_d;
  logic [MAX_DW-1:0] data_m;
  logic              par_d;
  logic [CNT_W-1:0]  stop_rld;
  logic              cts_ok;
  logic              xfer;

`ifdef UART_TX_CTS_EN
  logic [1:0] cts_sync_q;

  // Two-flop synchroniser on cts_n; resets high so nothing is accepted until
  // the pin has been seen low for two clks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cts_sync_q <= 2'b11;
    else     cts_sync_q <= {cts_sync_q[0], cts_n};
  end

  assign cts_ok = ~cts_sync_q[1];
`else
  assign cts_ok = 1'b1;
`endif

  // Ready is purely a function of state so a source sees it during reset too.
  assign in_if.in_ready = (state_q == IDLE) && cts_ok;
  assign xfer           = in_if.in_valid && in_if.in_ready;

  // Clamp the requested length and compute parity over the bits that will
  // actually be sent, so the frame format is fully decided at accept time.
  always_comb begin
    dlen_d = dlen;
    if (dlen < DL_MIN)      dlen_d = DL_MIN;
    else if (dlen > DL_MAX) dlen_d = DL_MAX;
    data_m = '0;
    for (int i = 0; i < MAX_DW; i++)
      data_m[i] = in_if.in_data[i] & (i < int'(dlen_d));
    if (sticky_parity) par_d = ~eps;
    else               par_d = eps ? (^data_m) : ~(^data_m);
  end

  // Stop-bit length: 1, 1.5 (only for 5-bit frames) or 2 bit times.
  always_comb begin
    stop_rld = BIT_RLD;
    if (stb_q) stop_rld = (dlen_q == DL_MIN) ? STOP15_R : STOP2_R;
  end

  // Frame sequencer: accept a word in IDLE, then walk start/data/parity/stop
  // one bit per OVERSAMPLE baud pulses; the pin follows tx_data one clk later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      timer_q   <= BIT_RLD;
      sh_q      <= '0;
      bitcnt_q  <= '0;
      dlen_q    <= DL_MIN;
      pen_q     <= 1'b0;
      stb_q     <= 1'b0;
      par_q     <= 1'b0;
      tx_data_q <= 1'b1;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      tx_q   <= tx_data_q & ~set_break;
      if (state_q == IDLE) begin
        // Timer is held at reload, so a pulse coinciding with accept is ignored.
        timer_q <= BIT_RLD;
        if (xfer) begin
          sh_q      <= in_if.in_data;
          dlen_q    <= dlen_d;
          pen_q     <= pen;
          stb_q     <= stb;
          par_q     <= par_d;
          tx_data_q <= 1'b0;
          busy_q    <= 1'b1;
          state_q   <= START;
        end
      end else if (baud_pulse) begin
        if (timer_q != '0) begin
          timer_q <= timer_q - 1'b1;
        end else begin
          timer_q <= BIT_RLD;
          case (state_q)
            START: begin
              tx_data_q <= sh_q[0];
              sh_q      <= sh_q >> 1;
              bitcnt_q  <= dlen_q - DL_W'(1);
              state_q   <= DATA;
            end
            DATA: begin
              if (bitcnt_q != '0) begin
                tx_data_q <= sh_q[0];
                sh_q      <= sh_q >> 1;
                bitcnt_q  <= bitcnt_q - DL_W'(1);
              end else if (pen_q) begin
                tx_data_q <= par_q;
                state_q   <= PARITY;
              end else begin
                tx_data_q <= 1'b1;
                timer_q   <= stop_rld;
                state_q   <= STOP;
              end
            end
            PARITY: begin
              tx_data_q <= 1'b1;
              timer_q   <= stop_rld;
              state_q   <= STOP;
            end
            STOP: begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule
